// File: rtl/scan_mux_pkg.sv
// Shared encodings for the scan_mux channel sweeper.
package scan_mux_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;
endpackage

// File: rtl/scan_mux_chan_select.sv
// Combinational CHANNELS:1 select of WIDTH-bit lanes; out-of-range index yields zero.
module chan_select #(
  parameter int CHANNELS = 16,
  parameter int WIDTH    = 1,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]          idx_i,
  output logic [WIDTH-1:0]          q_o
);
  always_comb begin
    q_o = '0;
    for (int c = 0; c < CHANNELS; c++)
      if (idx_i == SEL_W'(c)) q_o = data_i[c*WIDTH +: WIDTH];
  end
endmodule

// File: rtl/scan_mux.sv
// Registered N:1 channel mux with valid/ready output and a scan sweeper.
// Optional SCAN_MUX_PARITY_EN adds a registered even-parity output.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int CHANNELS = 16,
  parameter int WIDTH    = 1,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] data,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic                      mode,
  input  logic                      cont,
  input  logic                      start,
  input  logic                      stop,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
`ifdef SCAN_MUX_PARITY_EN
  output logic                      out_parity,
`endif
  output logic                      busy
);
  state_e             state_q, state_d;
  logic               oneshot_q, oneshot_d;
  logic               cont_q, cont_d;
  logic               stop_q, stop_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SEL_W-1:0]   chan_q, chan_d;
  logic [SEL_W-1:0]   nxt_chan;
  logic [WIDTH-1:0]   sel_data;
  logic               cap;
  logic               accept;

  // The mux always looks at the channel about to be captured, so data is
  // only ever sampled on a capture edge.
  chan_select #(.CHANNELS(CHANNELS), .WIDTH(WIDTH), .SEL_W(SEL_W)) u_sel (
    .data_i (data),
    .idx_i  (nxt_chan),
    .q_o    (sel_data)
  );

  assign accept = valid_q && out_ready;

  always_comb begin
    state_d   = state_q;
    oneshot_d = oneshot_q;
    cont_d    = cont_q;
    stop_d    = stop_q;
    valid_d   = valid_q;
    data_d    = data_q;
    chan_d    = chan_q;
    nxt_chan  = chan_q + SEL_W'(1);
    cap       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stop_d = 1'b0;
        if (start && !stop) begin
          cap       = 1'b1;
          oneshot_d = (mode == MODE_MANUAL);
          cont_d    = cont;
          nxt_chan  = (mode == MODE_MANUAL) ? sel_in : '0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        stop_d = stop_q | stop;
        if (accept) begin
          if (oneshot_q || stop_q || stop) begin
            valid_d = 1'b0;
            stop_d  = 1'b0;
            state_d = ST_IDLE;
          end else if (chan_q != SEL_W'(CHANNELS-1)) begin
            cap = 1'b1;
          end else if (cont_q) begin
            cap      = 1'b1;
            nxt_chan = '0;
          end else begin
            valid_d = 1'b0;
            stop_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (cap) begin
      valid_d = 1'b1;
      data_d  = sel_data;
      chan_d  = nxt_chan;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      oneshot_q <= 1'b0;
      cont_q    <= 1'b0;
      stop_q    <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      chan_q    <= '0;
    end else begin
      state_q   <= state_d;
      oneshot_q <= oneshot_d;
      cont_q    <= cont_d;
      stop_q    <= stop_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      chan_q    <= chan_d;
    end
  end

`ifdef SCAN_MUX_PARITY_EN
  logic parity_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   parity_q <= 1'b0;
    else if (cap) parity_q <= ^sel_data;
  end
  assign out_parity = parity_q;
`endif

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign busy      = (state_q == ST_RUN);
endmodule
